// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the MEM-stage to external SRAM bridge.
package sram_controller_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } state_t;

    localparam logic [31:0] BASE_ADDR_DEFAULT   = 32'd1024;
    localparam int unsigned SRAM_DATA_W         = 16;
    localparam int unsigned SRAM_ADDR_W_DEFAULT = 18;
    localparam int unsigned WAIT_CNT_W          = 4;

endpackage

// File: rtl/sram_controller.sv
// Serves 32-bit MEM-stage loads/stores as two 16-bit asynchronous SRAM accesses,
// holding ready low while an access is in flight.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned SRAM_ADDR_W = SRAM_ADDR_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    inout  wire logic [SRAM_DATA_W-1:0] SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_OE_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N
);

    state_t                  state, state_n;
    logic [WAIT_CNT_W-1:0]   wait_cnt;
    logic                    last_cycle;
    logic                    op_wr;
    logic [SRAM_ADDR_W-2:0]  pair_idx;
    logic [31:0]             wdata_q;
    logic                    dq_oe;
    logic [SRAM_DATA_W-1:0]  dq_out;

    assign last_cycle = (wait_cnt == WAIT_CNT_W'(WAIT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt  <= '0;
            op_wr     <= 1'b0;
            pair_idx  <= '0;
            wdata_q   <= '0;
            read_data <= '0;
        end else begin
            if (state_n != state)
                wait_cnt <= '0;
            else if (state == LOW || state == HIGH)
                wait_cnt <= wait_cnt + 1'b1;

            // Word index of the halfword pair; the byte offset bits and anything
            // above the SRAM range are dropped so out-of-range addresses wrap.
            if (state == IDLE && (rd_en || wr_en)) begin
                op_wr    <= wr_en;
                pair_idx <= (SRAM_ADDR_W-1)'((address - BASE_ADDR) >> 2);
                wdata_q  <= write_data;
            end

            if (!op_wr && last_cycle) begin
                if (state == LOW)
                    read_data[15:0] <= SRAM_DQ;
                else if (state == HIGH)
                    read_data[31:16] <= SRAM_DQ;
            end
        end
    end

    always_comb begin
        state_n   = state;
        ready     = 1'b0;
        SRAM_ADDR = '0;
        SRAM_WE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        SRAM_CE_N = 1'b1;
        SRAM_UB_N = 1'b0;
        SRAM_LB_N = 1'b0;
        dq_oe     = 1'b0;
        dq_out    = wdata_q[15:0];

        case (state)
            IDLE: begin
                ready = ~rd_en & ~wr_en;
                if (rd_en || wr_en) state_n = LOW;
            end
            LOW: begin
                SRAM_CE_N = 1'b0;
                SRAM_ADDR = {pair_idx, 1'b0};
                SRAM_WE_N = ~op_wr;
                SRAM_OE_N = op_wr;
                dq_oe     = op_wr;
                if (last_cycle) state_n = HIGH;
            end
            HIGH: begin
                SRAM_CE_N = 1'b0;
                SRAM_ADDR = {pair_idx, 1'b1};
                SRAM_WE_N = ~op_wr;
                SRAM_OE_N = op_wr;
                dq_oe     = op_wr;
                dq_out    = wdata_q[31:16];
                if (last_cycle) state_n = DONE;
            end
            DONE: begin
                ready   = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign SRAM_DQ = dq_oe ? dq_out : 'z;

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller with an inline behavioural 256K x 16 SRAM.
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] address, write_data;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        we_n, oe_n, ce_n, ub_n, lb_n;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        int          we_cyc;
        int          oe_cyc;
    } exp_t;

    exp_t sb[$];

    logic [15:0] mem [0:(1<<18)-1];

    always #5 clk = ~clk;

    sram_controller #(
        .BASE_ADDR   (32'd1024),
        .WAIT_CYCLES (2),
        .SRAM_ADDR_W (18)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_DQ    (sram_dq),
        .SRAM_ADDR  (sram_addr),
        .SRAM_WE_N  (we_n),
        .SRAM_OE_N  (oe_n),
        .SRAM_CE_N  (ce_n),
        .SRAM_UB_N  (ub_n),
        .SRAM_LB_N  (lb_n)
    );

    // Behavioural SRAM: asynchronous read on OE_N, write while WE_N is low.
    assign sram_dq = (!ce_n && !oe_n) ? mem[sram_addr] : 16'hzzzz;

    always @(posedge clk)
        if (!ce_n && !we_n) mem[sram_addr] <= sram_dq;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: tallies each busy window and checks it when ready comes back.
    int lowc = 0, wec = 0, oec = 0, cec = 0;
    always @(negedge clk) begin
        if (!rst) begin
            lowc = 0; wec = 0; oec = 0; cec = 0;
        end else begin
            chk("oe_we_exclusive", {31'd0, !oe_n && !we_n}, 32'd0);
            if (!ready) begin
                lowc++;
                if (!we_n) wec++;
                if (!oe_n) oec++;
                if (!ce_n) cec++;
            end else if (lowc > 0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_completion", 32'(lowc), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk({e.name, "_latency"},   32'(lowc), 32'd5);
                    chk({e.name, "_read_data"}, read_data, e.rdata);
                    chk({e.name, "_we_cycles"}, 32'(wec), 32'(e.we_cyc));
                    chk({e.name, "_oe_cycles"}, 32'(oec), 32'(e.oe_cyc));
                    chk({e.name, "_ce_cycles"}, 32'(cec), 32'd4);
                end
                lowc = 0; wec = 0; oec = 0; cec = 0;
            end
        end
    end

    task automatic wait_done(input string name, input bit scramble);
        bit done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk); #1;
            if (scramble && i == 1) begin
                address    = ~address;
                write_data = ~write_data;
            end
            if (ready) done = 1;
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL %s_timeout: got ready=0 want ready=1 within 40 cycles", name);
        end
        @(posedge clk); #1;
    endtask

    task automatic access(input logic wr, input logic rd, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rd,
                          input string name, input bit scramble);
        wr_en = wr; rd_en = rd; address = a; write_data = d;
        sb.push_back('{name, exp_rd, wr ? 4 : 0, wr ? 0 : 4});
        #1 chk({name, "_ready_drop"}, {31'd0, ready}, 32'd0);
        wait_done(name, scramble);
    endtask

    task automatic idle(input int n);
        wr_en = 0; rd_en = 0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int quiet;
        rst = 0; wr_en = 0; rd_en = 0; address = '0; write_data = '0;
        #3;
        chk("rst_ready",     {31'd0, ready}, 32'd1);
        chk("rst_read_data", read_data, 32'd0);
        chk("rst_addr",      {14'd0, sram_addr}, 32'd0);
        chk("rst_strobes",   {27'd0, we_n, oe_n, ce_n, ub_n, lb_n}, 32'b11100);
        repeat (2) @(posedge clk);
        #1 rst = 1;
        idle(1);

        access(1, 0, 32'd1024, 32'h12345678, 32'h0, "store_1024", 0);
        chk("mem0", {16'd0, mem[0]}, 32'h5678);
        chk("mem1", {16'd0, mem[1]}, 32'h1234);
        idle(2);

        access(0, 1, 32'd1026, 32'h0, 32'h12345678, "load_1026", 1);
        idle(1);

        access(1, 0, 32'd1028, 32'hDEADBEEF, 32'h12345678, "store_1028", 1);
        access(0, 1, 32'd1028, 32'h0, 32'hDEADBEEF, "load_1028_b2b", 0);
        chk("mem2", {16'd0, mem[2]}, 32'hBEEF);
        chk("mem3", {16'd0, mem[3]}, 32'hDEAD);
        idle(1);

        access(1, 1, 32'd1032, 32'h0000A5A5, 32'hDEADBEEF, "both_en_1032", 0);
        chk("mem4", {16'd0, mem[4]}, 32'hA5A5);
        chk("mem5", {16'd0, mem[5]}, 32'h0000);
        idle(1);

        access(1, 0, 32'd1020, 32'hCAFEF00D, 32'hDEADBEEF, "store_wrap_1020", 0);
        chk("mem_3fffe", {16'd0, mem[18'h3FFFE]}, 32'hF00D);
        chk("mem_3ffff", {16'd0, mem[18'h3FFFF]}, 32'hCAFE);
        idle(1);

        // Reset asserted in the middle of HIGH of a read.
        rd_en = 1; wr_en = 0; address = 32'd1024;
        repeat (3) @(posedge clk);
        #2 rst = 0;
        #1;
        chk("midrst_strobes",   {29'd0, we_n, oe_n, ce_n}, 32'b111);
        chk("midrst_read_data", read_data, 32'd0);
        chk("midrst_addr",      {14'd0, sram_addr}, 32'd0);
        chk("midrst_ready_req", {31'd0, ready}, 32'd0);
        rd_en = 0;
        #1 chk("midrst_ready_noreq", {31'd0, ready}, 32'd1);
        rd_en = 1;
        @(posedge clk);
        #1 rst = 1;
        sb.push_back('{"load_after_reset", 32'h12345678, 0, 4});
        wait_done("load_after_reset", 0);

        wr_en = 0; rd_en = 0;
        quiet = 0;
        repeat (20) begin
            @(negedge clk);
            if (ready !== 1'b1 || ce_n !== 1'b1 || we_n !== 1'b1 || oe_n !== 1'b1) quiet++;
        end
        chk("idle_quiet_cycles", 32'(quiet), 32'd0);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
